// File: rtl/z80_sysctl_pkg.sv
// Shared types, default constants and address-match helper for the Z80 system-control slave.
// Latency: none (package). Backpressure: n/a.
package z80_sysctl_pkg;

    localparam logic [15:0] IN_BASE_DK      = 16'h7C00;
    localparam logic [15:0] LATCH_BASE_DK   = 16'h7D80;
    localparam logic [15:0] LATCH_RST_DK    = 16'h0007;
    localparam int          NMI_MASK_BIT_DK = 4;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  dmaster;
        logic        rdn;
        logic        wrn;
        logic        inta;
    } z80_mbus_t;

    typedef struct packed {
        logic [7:0] dslave;
        logic       mwait;
    } z80_sbus_t;

    function automatic logic addr_hit(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input logic [15:0] ofs);
        return addr == 16'(base + ofs);
    endfunction

endpackage

// File: rtl/z80_wait_gen.sv
// Access-start detector plus 4-bit down-counter that holds mwait low for WAIT_CYCLES cycles.
// Latency: mwait drops combinationally in the start cycle. Backpressure: mwait is the backpressure to the CPU.
module z80_wait_gen #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic acc,
    output logic start,
    output logic mwait
);

    localparam logic [3:0] WAIT_LD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    logic       acc_d;
    logic [3:0] cnt;

    assign start = acc & ~acc_d & ~rst;
    assign mwait = rst | ~((start && (WAIT_CYCLES > 0)) || (cnt != 4'd0));

    // acc_d resets high so an access still held across reset is dropped, not restarted.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_d <= 1'b1;
            cnt   <= 4'd0;
        end else begin
            acc_d <= acc;
            if (!acc)
                cnt <= 4'd0;
            else if (start)
                cnt <= WAIT_LD;
            else if (cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: rtl/z80_sysctl.sv
// Z80 system-control slave: input ports, addressable latch, vblank NMI, wait states (optional IRQ via Z80_SYSCTL_IRQ_EN).
// Latency: read data registered, valid one clk after ena; latch/NMI update on the next edge. Backpressure: mwait wait states.
module z80_sysctl
    import z80_sysctl_pkg::*;
#(
    parameter int          NUM_IN         = 4,
    parameter logic [15:0] IN_BASE        = IN_BASE_DK,
    parameter int          IN_STRIDE_LOG2 = 7,
    parameter int          LATCH_BITS     = 8,
    parameter logic [15:0] LATCH_BASE     = LATCH_BASE_DK,
    parameter logic [15:0] LATCH_RST      = LATCH_RST_DK,
    parameter logic [15:0] LATCH_INV      = 16'h0007,
    parameter int          NMI_MASK_BIT   = NMI_MASK_BIT_DK,
    parameter int          WAIT_CYCLES    = 0
`ifdef Z80_SYSCTL_IRQ_EN
    ,
    parameter int          IRQ_MASK_BIT   = 0,
    parameter logic [7:0]  INT_VECTOR     = 8'hFF
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  z80_mbus_t                 ibus,
    output z80_sbus_t                 obus,
    input  logic [NUM_IN-1:0][7:0]    in_ports,
    input  logic                      vblk,
    output logic [LATCH_BITS-1:0]     latch_q,
    output logic                      nmi_n,
    output logic                      int_n
);

    logic                  rd;
    logic                  wr;
    logic                  acc;
    logic                  start;
    logic                  mwait_w;
    logic [7:0]            rd_dat;
    logic [7:0]            dslave_nxt;
    logic [7:0]            dslave_q;
    logic [LATCH_BITS-1:0] latch_nxt;
    logic                  vblk_d;
    logic                  vblk_rise;
    logic                  nmi_pend;

    assign rd        = ena & ~ibus.rdn;
    assign wr        = ena & ~ibus.wrn;
    assign acc       = rd | wr;
    assign vblk_rise = vblk & ~vblk_d;

    z80_wait_gen #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk   (clk),
        .rst   (rst),
        .acc   (acc),
        .start (start),
        .mwait (mwait_w)
    );

    always_comb begin
        rd_dat = 8'hFF;
        for (int k = 0; k < NUM_IN; k++) begin
            if (addr_hit(ibus.addr, IN_BASE, 16'(k << IN_STRIDE_LOG2)))
                rd_dat = in_ports[k];
        end
    end

    // Latch bits are only written in the start cycle, so a held write fires once.
    always_comb begin
        latch_nxt = latch_q;
        if (start && wr) begin
            for (int i = 0; i < LATCH_BITS; i++) begin
                if (addr_hit(ibus.addr, LATCH_BASE, 16'(i)))
                    latch_nxt[i] = ibus.dmaster[0] ^ LATCH_INV[i];
            end
        end
    end

`ifdef Z80_SYSCTL_IRQ_EN
    logic inta_ack;
    logic irq_pend;

    assign inta_ack = ena & ibus.inta;

    always_ff @(posedge clk) begin
        if (rst)
            irq_pend <= 1'b0;
        else
            irq_pend <= latch_nxt[IRQ_MASK_BIT] & ~inta_ack
                        & (irq_pend | (vblk_rise & latch_q[IRQ_MASK_BIT]));
    end

    assign int_n = ~irq_pend;

    always_comb begin
        dslave_nxt = rd ? rd_dat : 8'hFF;
        if (inta_ack)
            dslave_nxt = INT_VECTOR;
    end
`else
    logic unused_inta;

    assign unused_inta = ibus.inta;
    assign int_n       = 1'b1;

    always_comb begin
        dslave_nxt = rd ? rd_dat : 8'hFF;
    end
`endif

    // Gating with the next mask value lets a same-cycle mask clear beat a vblk rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            dslave_q <= 8'hFF;
            latch_q  <= LATCH_RST[LATCH_BITS-1:0];
            vblk_d   <= 1'b0;
            nmi_pend <= 1'b0;
        end else begin
            dslave_q <= dslave_nxt;
            latch_q  <= latch_nxt;
            vblk_d   <= vblk;
            nmi_pend <= latch_nxt[NMI_MASK_BIT]
                        & (nmi_pend | (vblk_rise & latch_q[NMI_MASK_BIT]));
        end
    end

    assign nmi_n = ~nmi_pend;
    assign obus  = '{dslave: dslave_q, mwait: mwait_w};

endmodule
